game_state_fsm: RTL and testbench
=================================

// Module: game_state_fsm
// PURPOSE
//   Top-level game sequencer that sits directly upstream of snake_controller.
//   Conditions the four active-low buttons and runs the 4-state game FSM
//   (DIFF_SELECTION/PLAYING/WIN/GAME_OVER). Drives snake_controller's state input.
//   Generates the per-move tick at a difficulty-dependent rate.
//   Consumes snake_controller's collision flag and snake length.
// PARAMETERS
//   TICK_EASY    default 25_000_000  clk cycles per move, difficulty 0
//   TICK_MEDIUM  default 12_500_000  clk cycles per move, difficulty 1
//   TICK_HARD    default 6_250_000   clk cycles per move, difficulty 2
//   WIN_LENGTH   default 16          snake length that wins (= BODY_LENGTH downstream)
//   LEN_W        default 5           width of snake_length
// PORTS
//   clk           in   1      system clock, rising edge
//   rst           in   1      reset; asynchronous, active-low
//   up_button     in   1      active-low, asynchronous to clk
//   right_button  in   1      active-low, asynchronous to clk
//   down_button   in   1      active-low, asynchronous to clk
//   left_button   in   1      active-low, asynchronous to clk
//   collision     in   1      high = snake hit wall/self (from snake_controller)
//   snake_length  in   LEN_W  current body length (from snake_controller)
//   state         out  2      00 DIFF_SELECTION, 01 PLAYING, 10 WIN, 11 GAME_OVER
//   difficulty    out  2      0..2; value 3 never driven
//   move_tick     out  1      1-cycle pulse; advances snake one cell
//   paused        out  1      high while paused (PAUSE_EN only; else tied 0)
// BEHAVIOUR
//   Reset (rst=0, async): state=00, difficulty=0, move_tick=0, paused=0,
//     tick counter=0; all sync/prev-button flops=1 (released).
//   Buttons: 2-flop synchroniser, then a prev flop.
//     press = sync_out==0 && prev==1 (one pulse per falling edge; held button = one press).
//     Pin falls before edge k -> outputs update at edge k+2.
//   DIFF_SELECTION:
//     up press: difficulty+1, saturates at 2. down press: difficulty-1, saturates at 0.
//     up+down pressed the same cycle: no change.
//     right press: go to PLAYING and clear the counter. Confirm has priority;
//       difficulty is unchanged on that cycle. left press is ignored.
//   PLAYING: difficulty is frozen.
//     Counter counts 0..P-1, where P = TICK_x for the current difficulty.
//     When the counter = P-1: move_tick=1 for 1 cycle, counter wraps to 0.
//     First tick occurs P cycles after entry.
//     Checked every cycle, priority order:
//       collision=1 -> GAME_OVER;
//       else snake_length >= WIN_LENGTH -> WIN.
//     No move_tick on the cycle that registers the exit.
//   WIN / GAME_OVER: counter held at 0, move_tick=0.
//     left press -> DIFF_SELECTION (difficulty retained); other presses ignored.
//   collision/snake_length are ignored outside PLAYING.
//   Reset mid-game: immediate return to reset values regardless of state; no tick is emitted.
//   All outputs are registered; no combinational input->output path.
// CONFIGURATION
//   `define PAUSE_EN:
//     In PLAYING, a left press toggles paused.
//     While paused: counter frozen, move_tick=0; collision/win checks remain active.
//     Leaving PLAYING clears paused.
//   Without PAUSE_EN: left press is ignored in PLAYING; paused is constant 0.
// TESTING (TICK_EASY=4, TICK_MEDIUM=3, TICK_HARD=2, WIN_LENGTH=16)
//   1. Reset, then up x3, down x1 (each pulse 1 cycle low) -> difficulty 0->1->2->2->1; state stays 00.
//   2. From 1: right press -> state=01 at 2nd edge after sync; move_tick every 3 cycles, exactly 1 cycle wide.
//   3. PLAYING, collision=1 and snake_length=16 same cycle -> state=11, no further move_tick.
//   4. PLAYING, snake_length 15->16 -> state=10. Then left press -> state=00, difficulty unchanged.
//   5. Button held low 20 cycles in DIFF_SELECTION -> exactly one increment; rst=0 mid-PLAYING -> state=00, difficulty=0 asynchronously.
//   6. PAUSE_EN: left press in PLAYING -> paused=1, no ticks for 10 cycles; 2nd press resumes from frozen count. Without macro: paused=0, ticks continue.

Source files
------------

// File: rtl/game_state_fsm_if.sv
// Bus between the game sequencer and its neighbours: raw buttons and snake status in,
// game state, difficulty, move tick and pause flag out.
interface game_state_fsm_if #(
    parameter int unsigned LEN_W = 5
);
    logic             up_button;
    logic             right_button;
    logic             down_button;
    logic             left_button;
    logic             collision;
    logic [LEN_W-1:0] snake_length;
    logic [1:0]       state;
    logic [1:0]       difficulty;
    logic             move_tick;
    logic             paused;

    modport master (
        output up_button,
        output right_button,
        output down_button,
        output left_button,
        output collision,
        output snake_length,
        input  state,
        input  difficulty,
        input  move_tick,
        input  paused
    );

    modport slave (
        input  up_button,
        input  right_button,
        input  down_button,
        input  left_button,
        input  collision,
        input  snake_length,
        output state,
        output difficulty,
        output move_tick,
        output paused
    );
endinterface

// File: rtl/game_state_fsm.sv
// Game sequencer: button conditioning, DIFF_SELECTION/PLAYING/WIN/GAME_OVER FSM and move tick.
// Optional feature: define PAUSE_EN to let a left press toggle pause while PLAYING.
module game_state_fsm #(
    parameter int unsigned TICK_EASY   = 25_000_000,
    parameter int unsigned TICK_MEDIUM = 12_500_000,
    parameter int unsigned TICK_HARD   = 6_250_000,
    parameter int unsigned WIN_LENGTH  = 16,
    parameter int unsigned LEN_W       = 5
) (
    input logic            clk_i,
    input logic            rst_ni,
    game_state_fsm_if.slave bus
);

    localparam logic [1:0] StDiffSel  = 2'b00;
    localparam logic [1:0] StPlaying  = 2'b01;
    localparam logic [1:0] StWin      = 2'b10;
    localparam logic [1:0] StGameOver = 2'b11;

    localparam int unsigned BtnUp    = 3;
    localparam int unsigned BtnRight = 2;
    localparam int unsigned BtnDown  = 1;
    localparam int unsigned BtnLeft  = 0;

    localparam int unsigned TickMaxEm = (TICK_EASY > TICK_MEDIUM) ? TICK_EASY : TICK_MEDIUM;
    localparam int unsigned TickMax   = (TickMaxEm > TICK_HARD) ? TickMaxEm : TICK_HARD;
    localparam int unsigned CntW      = (TickMax > 2) ? $clog2(TickMax) : 1;

    logic [3:0]      btn_pins;
    logic [3:0]      btn_meta_q, btn_sync_q, btn_prev_q;
    logic [3:0]      press;
    logic [1:0]      state_q, state_d;
    logic [1:0]      diff_q, diff_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] period_m1;
    logic            tick_q, tick_d;
    logic            paused_q, paused_d;
    logic            win_len;

    assign btn_pins = {bus.up_button, bus.right_button, bus.down_button, bus.left_button};

    // Falling edge of the synchronised level; a held button yields a single press.
    assign press = ~btn_sync_q & btn_prev_q;

    assign win_len = (32'(bus.snake_length) >= WIN_LENGTH);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_meta_q <= 4'hF;
            btn_sync_q <= 4'hF;
            btn_prev_q <= 4'hF;
        end else begin
            btn_meta_q <= btn_pins;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    always_comb begin
        case (diff_q)
            2'd0:    period_m1 = CntW'(TICK_EASY - 1);
            2'd1:    period_m1 = CntW'(TICK_MEDIUM - 1);
            default: period_m1 = CntW'(TICK_HARD - 1);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        paused_d = paused_q;
        case (state_q)
            StDiffSel: begin
                cnt_d    = '0;
                paused_d = 1'b0;
                // Confirm wins over any simultaneous difficulty change.
                if (press[BtnRight]) begin
                    state_d = StPlaying;
                end else if (press[BtnUp] && !press[BtnDown]) begin
                    if (diff_q != 2'd2) diff_d = diff_q + 2'd1;
                end else if (press[BtnDown] && !press[BtnUp]) begin
                    if (diff_q != 2'd0) diff_d = diff_q - 2'd1;
                end
            end
            StPlaying: begin
                if (bus.collision) begin
                    state_d  = StGameOver;
                    cnt_d    = '0;
                    paused_d = 1'b0;
                end else if (win_len) begin
                    state_d  = StWin;
                    cnt_d    = '0;
                    paused_d = 1'b0;
                end else begin
                    if (!paused_q) begin
                        if (cnt_q == period_m1) begin
                            cnt_d  = '0;
                            tick_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
`ifdef PAUSE_EN
                    if (press[BtnLeft]) paused_d = ~paused_q;
`endif
                end
            end
            default: begin
                cnt_d    = '0;
                paused_d = 1'b0;
                if (press[BtnLeft]) state_d = StDiffSel;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StDiffSel;
            diff_q   <= 2'd0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            paused_q <= paused_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.difficulty = diff_q;
    assign bus.move_tick  = tick_q;
    assign bus.paused     = paused_q;

endmodule

// File: tb/tb_game_state_fsm.sv
// Self-checking bench for game_state_fsm: vector table, directed corner sequences and a
// randomized run compared every cycle against a cycle-level behavioural model.
module tb_game_state_fsm;

    localparam int unsigned TEasy  = 4;
    localparam int unsigned TMed   = 3;
    localparam int unsigned THard  = 2;
    localparam int unsigned WinLen = 16;
    localparam int unsigned LenW   = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    bit   chk_en;

    game_state_fsm_if #(.LEN_W(LenW)) bus ();

    game_state_fsm #(
        .TICK_EASY  (TEasy),
        .TICK_MEDIUM(TMed),
        .TICK_HARD  (THard),
        .WIN_LENGTH (WinLen),
        .LEN_W      (LenW)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: h1/h2/h3 are the pin levels seen at the last three edges.
    typedef struct {
        int         st;
        int         diff;
        int         run;
        bit         tick;
        bit         paused;
        logic [3:0] h1;
        logic [3:0] h2;
        logic [3:0] h3;
    } model_t;

    model_t m;

    function automatic model_t m_reset();
        model_t r;
        r.st = 0; r.diff = 0; r.run = 0; r.tick = 0; r.paused = 0;
        r.h1 = 4'hF; r.h2 = 4'hF; r.h3 = 4'hF;
        return r;
    endfunction

    function automatic int period(input int d);
        return (d == 0) ? TEasy : (d == 1) ? TMed : THard;
    endfunction

    function automatic model_t m_step(input model_t c, input logic [3:0] pins, input bit coll,
                                      input int len);
        model_t     n;
        logic [3:0] pr;
        n      = c;
        n.tick = 0;
        pr     = ~c.h2 & c.h3;  // {up, right, down, left}
        case (c.st)
            0: begin
                if (pr[2]) begin
                    n.st  = 1;
                    n.run = 0;
                end else if (pr[3] && !pr[1]) n.diff = (c.diff == 2) ? 2 : c.diff + 1;
                else if (pr[1] && !pr[3]) n.diff = (c.diff == 0) ? 0 : c.diff - 1;
            end
            1: begin
                if (coll) begin
                    n.st = 3; n.paused = 0;
                end else if (len >= WinLen) begin
                    n.st = 2; n.paused = 0;
                end else begin
                    if (!c.paused) begin
                        n.run = c.run + 1;
                        if (n.run % period(c.diff) == 0) n.tick = 1;
                    end
`ifdef PAUSE_EN
                    if (pr[0]) n.paused = !c.paused;
`endif
                end
            end
            default: if (pr[0]) n.st = 0;
        endcase
        n.h3 = c.h2;
        n.h2 = c.h1;
        n.h1 = pins;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= m_reset();
        else m <= m_step(m, {bus.up_button, bus.right_button, bus.down_button, bus.left_button},
                         bus.collision, int'(bus.snake_length));
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_state", int'(bus.state), m.st);
            chk("model_diff", int'(bus.difficulty), m.diff);
            chk("model_tick", int'(bus.move_tick), int'(m.tick));
            chk("model_paused", int'(bus.paused), int'(m.paused));
        end
    end

    task automatic set_pins(input logic [3:0] p);
        bus.up_button    = p[3];
        bus.right_button = p[2];
        bus.down_button  = p[1];
        bus.left_button  = p[0];
    endtask

    // One-cycle low pulse on the masked pins; returns once the press has registered.
    task automatic press(input logic [3:0] mask);
        @(negedge clk) set_pins(~mask);
        @(negedge clk) set_pins(4'hF);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] mask;
        int         exp_state;
        int         exp_diff;
    } vec_t;

    vec_t vecs[7];
    int   ticks;

    initial begin
        checks = 0;
        passes = 0;
        chk_en = 0;
        rst_n  = 1'b0;
        set_pins(4'hF);
        bus.collision    = 1'b0;
        bus.snake_length = '0;

        vecs[0] = '{4'b1000, 0, 1};  // up
        vecs[1] = '{4'b1000, 0, 2};  // up
        vecs[2] = '{4'b1000, 0, 2};  // up saturates
        vecs[3] = '{4'b0010, 0, 1};  // down
        vecs[4] = '{4'b1010, 0, 1};  // up+down together
        vecs[5] = '{4'b0001, 0, 1};  // left ignored
        vecs[6] = '{4'b1100, 1, 1};  // right with up: confirm wins

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_state", int'(bus.state), 0);
        chk("rst_diff", int'(bus.difficulty), 0);
        chk("rst_tick", int'(bus.move_tick), 0);
        chk("rst_paused", int'(bus.paused), 0);
        chk_en = 1;

        for (int i = 0; i < 6; i++) begin
            press(vecs[i].mask);
            chk($sformatf("vec%0d_state", i), int'(bus.state), vecs[i].exp_state);
            chk($sformatf("vec%0d_diff", i), int'(bus.difficulty), vecs[i].exp_diff);
        end

        // Confirm latency and tick cadence at difficulty 1.
        @(negedge clk) set_pins(4'b1011);
        @(negedge clk) set_pins(4'hF);
        chk("entry_k", int'(bus.state), 0);
        @(negedge clk);
        chk("entry_k1", int'(bus.state), 0);
        @(negedge clk);
        chk("entry_k2", int'(bus.state), 1);
        chk("entry_tick", int'(bus.move_tick), 0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk($sformatf("cadence%0d", i), int'(bus.move_tick), (i % 3 == 0) ? 1 : 0);
        end

        // Collision and win length in the same cycle: collision wins.
        bus.collision    = 1'b1;
        bus.snake_length = 5'd16;
        @(negedge clk);
        chk("coll_state", int'(bus.state), 3);
        chk("coll_tick", int'(bus.move_tick), 0);
        bus.collision    = 1'b0;
        bus.snake_length = '0;
        ticks = 0;
        repeat (6) begin
            @(negedge clk);
            ticks += int'(bus.move_tick);
        end
        chk("over_ticks", ticks, 0);

        press(4'b0001);
        chk("over_left_state", int'(bus.state), 0);
        chk("over_left_diff", int'(bus.difficulty), 1);

        press(vecs[6].mask);
        chk("vec6_state", int'(bus.state), vecs[6].exp_state);
        chk("vec6_diff", int'(bus.difficulty), vecs[6].exp_diff);
        bus.snake_length = 5'd15;
        repeat (3) @(negedge clk);
        chk("len15_state", int'(bus.state), 1);
        bus.snake_length = 5'd16;
        @(negedge clk);
        chk("len16_state", int'(bus.state), 2);
        bus.snake_length = '0;
        press(4'b1000);
        chk("win_up_ignored", int'(bus.state), 2);
        press(4'b0001);
        chk("win_left_state", int'(bus.state), 0);
        chk("win_left_diff", int'(bus.difficulty), 1);

        // Held button counts once.
        press(4'b0010);
        chk("down_to0", int'(bus.difficulty), 0);
        @(negedge clk) set_pins(4'b0111);
        repeat (20) @(negedge clk);
        set_pins(4'hF);
        repeat (3) @(negedge clk);
        chk("held_once", int'(bus.difficulty), 1);

        // Asynchronous reset while playing.
        press(4'b0100);
        chk("play_again", int'(bus.state), 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", int'(bus.state), 0);
        chk("async_diff", int'(bus.difficulty), 0);
        chk("async_tick", int'(bus.move_tick), 0);
        @(negedge clk) rst_n = 1'b1;

        // Pause behaviour at difficulty 0.
        press(4'b0100);
        chk("pause_entry", int'(bus.state), 1);
        repeat (2) @(negedge clk);
        press(4'b0001);
`ifdef PAUSE_EN
        chk("paused_on", int'(bus.paused), 1);
`else
        chk("paused_off", int'(bus.paused), 0);
`endif
        ticks = 0;
        repeat (10) begin
            @(negedge clk);
            ticks += int'(bus.move_tick);
        end
`ifdef PAUSE_EN
        chk("paused_ticks", ticks, 0);
`else
        chk("unpaused_ticks", int'(ticks >= 2), 1);
`endif
        press(4'b0001);
        chk("resume_paused", int'(bus.paused), 0);
        ticks = 0;
        repeat (8) begin
            @(negedge clk);
            ticks += int'(bus.move_tick);
        end
        chk("resume_ticks", int'(ticks >= 1), 1);
        chk("resume_state", int'(bus.state), 1);

        // Randomized run; the model comparison runs every cycle.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 799) == 0) rst_n = 1'b0;
            bus.up_button    = ($urandom_range(0, 11) != 0);
            bus.right_button = ($urandom_range(0, 15) != 0);
            bus.down_button  = ($urandom_range(0, 11) != 0);
            bus.left_button  = ($urandom_range(0, 9) != 0);
            bus.collision    = ($urandom_range(0, 59) == 0);
            bus.snake_length = ($urandom_range(0, 49) == 0) ? 5'($urandom_range(16, 31))
                                                            : 5'($urandom_range(0, 15));
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_pins(4'hF);
        @(negedge clk);
        chk_en = 0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
